// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//   Shares the single-port D-MEM between the pipeline MEM stage and a debug/loader
//   burst port. Pipeline traffic wins in IDLE/DONE; an active burst owns the port
//   and only yields to the pipeline once it has been stalled STARVE_LIMIT cycles.
//
// Ports
//   clk, reset                 clock, asynchronous active-low reset
//   pipe_req/we/addr/wdata     MEM-stage request
//   pipe_stall                 request not granted this cycle (combinational)
//   pipe_rvalid/rdata          load data, one cycle after a read grant
//   dbg_req/we/addr/len/wdata  burst request (sampled in IDLE only)
//   dbg_wready                 write beat issued this cycle (combinational)
//   dbg_rvalid/rdata           read beat data, one cycle after the beat
//   dbg_busy, dbg_done         burst in progress / one-cycle completion pulse
//   mem_en/we/addr/wdata       D-MEM access
//   mem_rdata                  D-MEM combinational read data
//
// State  | meaning
// IDLE   | pipe served on demand; dbg_req latches a burst
// BURST  | one beat per cycle unless the starved pipe is granted instead
// DONE   | dbg_done pulse; pipe may still be served
module dmem_port_arbiter #(
  parameter int ADDR_BITS    = 32,
  parameter int DATA_BITS    = 32,
  parameter int WORD_BITS    = 2,
  parameter int MAX_BURST    = 16,
  parameter int LEN_BITS     = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pipe_req,
  input  logic                 pipe_we,
  input  logic [ADDR_BITS-1:0] pipe_addr,
  input  logic [DATA_BITS-1:0] pipe_wdata,
  output logic                 pipe_stall,
  output logic                 pipe_rvalid,
  output logic [DATA_BITS-1:0] pipe_rdata,
  input  logic                 dbg_req,
  input  logic                 dbg_we,
  input  logic [ADDR_BITS-1:0] dbg_addr,
  input  logic [LEN_BITS-1:0]  dbg_len,
  input  logic [DATA_BITS-1:0] dbg_wdata,
  output logic                 dbg_wready,
  output logic                 dbg_rvalid,
  output logic [DATA_BITS-1:0] dbg_rdata,
  output logic                 dbg_busy,
  output logic                 dbg_done,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [DATA_BITS-1:0] mem_wdata,
  input  logic [DATA_BITS-1:0] mem_rdata
);

  localparam int SC_BITS = $clog2(STARVE_LIMIT + 1);
  localparam logic [ADDR_BITS-1:0] WORD_MASK = ADDR_BITS'((1 << WORD_BITS) - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_BITS-1:0]  r_base;
  logic                  r_we;
  logic [LEN_BITS-1:0]   r_len;
  logic [LEN_BITS-1:0]   r_beat_cnt;
  logic [SC_BITS-1:0]    r_starve_cnt;

  logic                  w_pipe_grant;
  logic                  w_beat;
  logic                  w_dbg_start;
  logic [LEN_BITS-1:0]   w_len_clamped;
  logic [ADDR_BITS-1:0]  w_beat_addr;

  assign w_len_clamped = (dbg_len > LEN_BITS'(MAX_BURST)) ? LEN_BITS'(MAX_BURST) : dbg_len;
  // Address arithmetic is modulo 2^ADDR_BITS, so a burst near the top wraps to 0.
  assign w_beat_addr   = r_base + (ADDR_BITS'(r_beat_cnt) << WORD_BITS);

  always_comb begin
    w_next       = r_state;
    w_pipe_grant = 1'b0;
    w_beat       = 1'b0;
    w_dbg_start  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (pipe_req) begin
          w_pipe_grant = 1'b1;
        end else if (dbg_req) begin
          w_dbg_start = 1'b1;
          w_next      = (w_len_clamped == '0) ? S_DONE : S_BURST;
        end
      end
      S_BURST: begin
        // A starved pipeline takes this slot; the beat counter simply holds.
        if (pipe_req && (r_starve_cnt == SC_BITS'(STARVE_LIMIT))) begin
          w_pipe_grant = 1'b1;
        end else begin
          w_beat = 1'b1;
          if (r_beat_cnt == (r_len - LEN_BITS'(1))) begin
            w_next = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_pipe_grant = pipe_req;
        w_next       = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
    // Outputs must be quiet while reset is held, independent of the clock.
    if (!reset) begin
      w_pipe_grant = 1'b0;
      w_beat       = 1'b0;
      w_dbg_start  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_base     <= '0;
      r_we       <= 1'b0;
      r_len      <= '0;
      r_beat_cnt <= '0;
    end else if (w_dbg_start) begin
      r_base     <= dbg_addr & ~WORD_MASK;
      r_we       <= dbg_we;
      r_len      <= w_len_clamped;
      r_beat_cnt <= '0;
    end else if (w_beat) begin
      r_beat_cnt <= r_beat_cnt + LEN_BITS'(1);
    end
  end

  // Outside BURST a pending pipe request is always granted, so the counter
  // only ever accumulates while a burst is holding the port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_starve_cnt <= '0;
    end else if ((r_state == S_BURST) && pipe_req && !w_pipe_grant) begin
      r_starve_cnt <= r_starve_cnt + SC_BITS'(1);
    end else begin
      r_starve_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe_rvalid <= 1'b0;
      pipe_rdata  <= '0;
      dbg_rvalid  <= 1'b0;
      dbg_rdata   <= '0;
    end else begin
      pipe_rvalid <= w_pipe_grant & ~pipe_we;
      if (w_pipe_grant && !pipe_we) begin
        pipe_rdata <= mem_rdata;
      end
      dbg_rvalid <= w_beat & ~r_we;
      if (w_beat && !r_we) begin
        dbg_rdata <= mem_rdata;
      end
    end
  end

  always_comb begin
    mem_en     = w_pipe_grant | w_beat;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (w_pipe_grant) begin
      mem_we    = pipe_we;
      mem_addr  = pipe_addr;
      mem_wdata = pipe_wdata;
    end else if (w_beat) begin
      mem_we    = r_we;
      mem_addr  = w_beat_addr;
      mem_wdata = dbg_wdata;
    end
  end

  assign pipe_stall = reset & pipe_req & ~w_pipe_grant;
  assign dbg_wready = w_beat & r_we;
  assign dbg_busy   = (r_state != S_IDLE);
  assign dbg_done   = (r_state == S_DONE);

endmodule
